// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU among NUM_REQ requesters
// with a single registered response slot returned to the owning requester.
package alu_arbiter_pkg;
    typedef enum logic [2:0] {
        CMD_ADD = 3'd0,
        CMD_SUB = 3'd1,
        CMD_AND = 3'd2,
        CMD_OR  = 3'd3,
        CMD_XOR = 3'd4,
        CMD_SLL = 3'd5,
        CMD_SRL = 3'd6,
        CMD_SRA = 3'd7
    } command_t;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  command_t           req_command [NUM_REQ],
    input  logic [31:0]        req_lhs [NUM_REQ],
    input  logic [31:0]        req_rhs [NUM_REQ],
    output command_t           alu_command,
    output logic [31:0]        alu_lhs,
    output logic [31:0]        alu_rhs,
    input  logic [31:0]        alu_res,
    output logic [NUM_REQ-1:0] rsp_valid,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output logic [31:0]        rsp_res
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;
    typedef logic [IW-1:0] idx_t;

    logic rsp_full;
    idx_t rsp_owner;
    idx_t rr_ptr;
    logic owner_ready;
    logic slot_free;
    logic grant_any;
    idx_t grant_idx;
    idx_t next_ptr;

    always_comb begin
        owner_ready = 1'b0;
        rsp_valid   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_full && rsp_owner == idx_t'(i)) begin
                rsp_valid[i] = 1'b1;
                owner_ready  = rsp_ready[i];
            end
        end
    end

    // A draining owner frees the slot in the same cycle, keeping one issue per cycle.
    assign slot_free = !rsp_full || owner_ready;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (slot_free && !grant_any && req_valid[i] &&
                    ((int'(rr_ptr) + k) % NUM_REQ) == i) begin
                    grant_any    = 1'b1;
                    grant_idx    = idx_t'(i);
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Idle cycles drive zeros so the shared ALU inputs do not toggle needlessly.
    always_comb begin
        alu_command = command_t'(3'd0);
        alu_lhs     = '0;
        alu_rhs     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                alu_command = req_command[i];
                alu_lhs     = req_lhs[i];
                alu_rhs     = req_rhs[i];
            end
        end
    end

    assign next_ptr = (grant_idx == idx_t'(NUM_REQ - 1)) ? '0 : idx_t'(grant_idx + 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_full  <= 1'b0;
            rsp_res   <= '0;
            rsp_owner <= '0;
            rr_ptr    <= '0;
        end else if (grant_any) begin
            rsp_full  <= 1'b1;
            rsp_res   <= alu_res;
            rsp_owner <= grant_idx;
            rr_ptr    <= next_ptr;
        end else if (owner_ready) begin
            rsp_full  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural
// round-robin/response-slot model and a local ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    command_t      req_command [N];
    logic [31:0]   req_lhs [N];
    logic [31:0]   req_rhs [N];
    command_t      alu_command;
    logic [31:0]   alu_lhs;
    logic [31:0]   alu_rhs;
    logic [31:0]   alu_res;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [31:0]   rsp_res;

    int checks = 0;
    int errors = 0;

    bit          m_full;
    logic [31:0] m_res;
    int          m_owner;
    int          m_ptr;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_command(req_command), .req_lhs(req_lhs), .req_rhs(req_rhs),
        .alu_command(alu_command), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res)
    );

    function automatic logic [31:0] alu_fn(command_t c, logic [31:0] a, logic [31:0] b);
        case (c)
            CMD_ADD: return a + b;
            CMD_SUB: return a - b;
            CMD_AND: return a & b;
            CMD_OR:  return a | b;
            CMD_XOR: return a ^ b;
            CMD_SLL: return a << b[4:0];
            CMD_SRL: return a >> b[4:0];
            default: return $unsigned($signed(a) >>> b[4:0]);
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_command, alu_lhs, alu_rhs);

    function automatic int exp_grant();
        if (m_full && !rsp_ready[m_owner]) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 0; m_res = 0; m_owner = 0; m_ptr = 0;
    endtask

    task automatic tick();
        int g;
        logic [31:0] r;
        g = exp_grant();
        r = 0;
        if (g >= 0) r = alu_fn(req_command[g], req_lhs[g], req_rhs[g]);
        @(posedge clk);
        if (g >= 0) begin
            m_full = 1; m_res = r; m_owner = g; m_ptr = (g + 1) % N;
        end else if (m_full && rsp_ready[m_owner]) begin
            m_full = 0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(int i, command_t c, logic [31:0] a, logic [31:0] b);
        req_command[i] = c; req_lhs[i] = a; req_rhs[i] = b;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) set_req(i, CMD_ADD, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        #1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid got %b want 000", rsp_valid); end
        checks++; if (rsp_res !== 32'd0) begin errors++; $display("FAIL reset_rsp_res got %h want 0", rsp_res); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
        req_valid = 3'b110;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL reset_ptr_search got %b want 010", req_ready); end
        req_valid = '0;
        #1;
    endtask

    task automatic test_single();
        set_req(0, CMD_ADD, 5, 7);
        req_valid = 3'b001;
        rsp_ready = 3'b001;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_grant got %b want 001", req_ready); end
        checks++; if (alu_lhs !== 32'd5 || alu_rhs !== 32'd7) begin errors++; $display("FAIL single_alu_drive got %h/%h want 5/7", alu_lhs, alu_rhs); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 3'b001) begin errors++; $display("FAIL single_rsp_valid got %b want 001", rsp_valid); end
        checks++; if (rsp_res !== 32'd12) begin errors++; $display("FAIL single_rsp_res got %0d want 12", rsp_res); end
        tick();
        checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL single_drained got %b want 000", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] e;
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, CMD_ADD, i, 100);
        req_valid = '1;
        rsp_ready = '1;
        for (int k = 0; k < 4; k++) begin
            #1;
            e = '0; e[k % N] = 1'b1;
            checks++; if (req_ready !== e) begin errors++; $display("FAIL rr_grant_%0d got %b want %b", k, req_ready, e); end
            if (k > 0) begin
                e = '0; e[(k - 1) % N] = 1'b1;
                checks++; if (rsp_valid !== e || rsp_res !== 32'(100 + (k - 1) % N)) begin
                    errors++; $display("FAIL rr_rsp_%0d got %b/%0d want %b/%0d", k, rsp_valid, rsp_res, e, 100 + (k - 1) % N);
                end
            end
            tick();
        end
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 3'b001 || rsp_res !== 32'd100) begin errors++; $display("FAIL rr_last got %b/%0d want 001/100", rsp_valid, rsp_res); end
        tick();
    endtask

    task automatic test_backpressure();
        set_req(1, CMD_SUB, 10, 3);
        set_req(0, CMD_ADD, 1, 1);
        req_valid = 3'b010;
        rsp_ready = 3'b000;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL bp_issue got %b want 010", req_ready); end
        tick();
        req_valid = 3'b001;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (rsp_valid !== 3'b010 || rsp_res !== 32'd7 || req_ready !== 3'b000) begin
                errors++; $display("FAIL bp_stall_%0d got v=%b res=%0d rdy=%b want 010/7/000", c, rsp_valid, rsp_res, req_ready);
            end
            tick();
        end
        rsp_ready = 3'b010;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL bp_release got %b want 001", req_ready); end
        tick();
        checks++; if (rsp_valid !== 3'b001 || rsp_res !== 32'd2) begin errors++; $display("FAIL bp_next got %b/%0d want 001/2", rsp_valid, rsp_res); end
        drain();
    endtask

    task automatic test_drain_issue();
        set_req(2, CMD_SLL, 1, 4);
        req_valid = 3'b100;
        rsp_ready = 3'b100;
        #1;
        tick();
        set_req(0, CMD_XOR, 32'hFF, 32'h0F);
        req_valid = 3'b001;
        #1;
        checks++; if (rsp_valid !== 3'b100 || rsp_res !== 32'd16) begin errors++; $display("FAIL di_first got %b/%0d want 100/16", rsp_valid, rsp_res); end
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL di_grant got %b want 001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 3'b001 || rsp_res !== 32'hF0) begin errors++; $display("FAIL di_overwrite got %b/%h want 001/f0", rsp_valid, rsp_res); end
        drain();
    endtask

    task automatic test_reset_mid();
        set_req(1, CMD_SUB, 10, 3);
        req_valid = 3'b010;
        rsp_ready = 3'b000;
        #1;
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 3'b010) begin errors++; $display("FAIL rm_pending got %b want 010", rsp_valid); end
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++; if (rsp_valid !== 3'b000 || rsp_res !== 32'd0) begin errors++; $display("FAIL rm_async got %b/%0d want 000/0", rsp_valid, rsp_res); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        set_req(0, CMD_ADD, 1, 2);
        set_req(1, CMD_ADD, 3, 4);
        req_valid = 3'b011;
        rsp_ready = 3'b011;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rm_contention got %b want 001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 3'b001 || rsp_res !== 32'd3) begin errors++; $display("FAIL rm_result got %b/%0d want 001/3", rsp_valid, rsp_res); end
        drain();
    endtask

    task automatic test_idle();
        for (int i = 0; i < N; i++) set_req(i, CMD_SRA, 32'hDEAD, 32'hBEEF);
        req_valid = '0;
        rsp_ready = '1;
        #1;
        checks++; if (alu_lhs !== 32'd0 || alu_rhs !== 32'd0 || alu_command !== command_t'(3'd0) || req_ready !== 3'b000) begin
            errors++; $display("FAIL idle_empty got %h/%h/%0d/%b want 0/0/0/000", alu_lhs, alu_rhs, alu_command, req_ready);
        end
        req_valid = 3'b001;
        rsp_ready = '0;
        #1;
        tick();
        req_valid = 3'b110;
        #1;
        checks++; if (alu_lhs !== 32'd0 || alu_command !== command_t'(3'd0) || req_ready !== 3'b000) begin
            errors++; $display("FAIL idle_full got %h/%0d/%b want 0/0/000", alu_lhs, alu_command, req_ready);
        end
        drain();
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_val;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) set_req(i, command_t'($urandom_range(0, 7)), $urandom, $urandom);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
            #1;
            g = exp_grant();
            e_rdy = '0;
            if (g >= 0) e_rdy[g] = 1'b1;
            e_val = '0;
            if (m_full) e_val[m_owner] = 1'b1;
            checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL rand_req_ready c=%0d got %b want %b", c, req_ready, e_rdy); end
            checks++; if (rsp_valid !== e_val) begin errors++; $display("FAIL rand_rsp_valid c=%0d got %b want %b", c, rsp_valid, e_val); end
            if (m_full) begin
                checks++; if (rsp_res !== m_res) begin errors++; $display("FAIL rand_rsp_res c=%0d got %h want %h", c, rsp_res, m_res); end
            end
            if (g >= 0) begin
                checks++; if (alu_lhs !== req_lhs[g] || alu_rhs !== req_rhs[g] || alu_command !== req_command[g]) begin
                    errors++; $display("FAIL rand_alu_drive c=%0d got %h/%h want %h/%h", c, alu_lhs, alu_rhs, req_lhs[g], req_rhs[g]);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) set_req(i, CMD_ADD, 0, 0);
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drain_issue();
        test_reset_mid();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between up to four requesters (e.g. execute stage, branch-compare unit, address generator) with round-robin arbitration. Each requester presents a command and operands with a valid/ready handshake; the granted request drives the ALU that cycle, and the result is registered and returned to the owning requester over its own valid/ready response channel. Throughput is one operation per cycle while the response register drains every cycle.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous reset, active low.
- `req_valid`  input  NUM_REQ  per-requester request valid.
- `req_ready`  output  NUM_REQ  per-requester grant; asserted on at most one bit.
- `req_command`  input  NUM_REQ x command_t  per-requester ALU command.
- `req_lhs`, `req_rhs`  input  NUM_REQ x 32  per-requester operands.
- `alu_command`  output  command_t  command driven to the shared ALU.
- `alu_lhs`, `alu_rhs`  output  32  operands driven to the shared ALU.
- `alu_res`  input  32  result returned by the ALU, same cycle.
- `rsp_valid`  output  NUM_REQ  per-requester response valid; at most one bit set.
- `rsp_ready`  input  NUM_REQ  per-requester response accept.
- `rsp_res`  output  32  registered result, shared by all response channels.

## Operation

- The response register holds `rsp_res`, `rsp_owner` (index) and `rsp_full`. `rsp_valid[i] = rsp_full && rsp_owner == i`.
- The slot is free when `!rsp_full`, or when `rsp_full && rsp_ready[rsp_owner]`, which frees it the same cycle.
- Arbitration:
  - Only occurs when the slot is free.
  - Picks the first asserted `req_valid[i]`, searching upward from `rr_ptr` with wrap-around modulo NUM_REQ.
  - Sets `req_ready[i]` for the winner only. When the slot is not free, all `req_ready` are 0.
- ALU drive:
  - When a grant exists, `alu_command/lhs/rhs` = the winner's inputs.
  - Otherwise `alu_command` = command_t value 0 and operands = 0, so idle toggling is deterministic.
- Issue (`req_valid[i] && req_ready[i]`):
  - Next cycle: `rsp_res = alu_res`, `rsp_owner = i`, `rsp_full = 1`.
  - `rr_ptr = (i + 1) mod NUM_REQ`.
- Drain without issue: `rsp_full` clears. `rsp_res` and `rsp_owner` hold their stale values.
- Simultaneous drain and issue: the new result overwrites the slot. `rsp_full` stays 1.
- `rr_ptr` is unchanged in any cycle with no issue.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. It never depends on `req_command` or the operands.
- Requesters must hold their inputs stable while `req_valid` is high and `req_ready` is low. The arbiter does not require this for correctness, because operands are sampled only on issue.
- `rsp_ready` for a non-owner, or while `rsp_full` is 0, is ignored.

## Timing

- Reset (`reset_n` low, asynchronous): `rsp_full = 0`, `rsp_res = 0`, `rsp_owner = 0`, `rr_ptr = 0`.
  - Consequently all `rsp_valid` = 0, and `req_ready` is per the arbitration rules.
  - A pending response is discarded.
  - Deassertion is synchronised externally. First arbitration is on the first rising edge after release.
- Latency: request issued in cycle N produces its response visible in cycle N+1.
- Back-to-back: with `rsp_ready` held high by the owner, one issue per cycle is sustained across any mix of requesters.
- Stall: while the owner holds `rsp_ready` low, `rsp_valid` and `rsp_res` stay stable and no new grant occurs.
- Fairness: with all requesters continuously valid and responses drained each cycle, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 issues.
- No combinational path from `alu_res` to any output other than through the response register.

## Test plan

- Reset then single request: requester 0, ADD, lhs=5, rhs=7, `rsp_ready[0]`=1 → `req_ready[0]`=1 in cycle 0; cycle 1 `rsp_valid[0]`=1, `rsp_res`=12; cycle 2 `rsp_valid`=0.
- Round-robin, NUM_REQ=3, all valid, all rsp_ready=1, requester i sends ADD lhs=i rhs=100 → grants 0,1,2,0 in consecutive cycles; responses 100,101,102,100 one cycle later, each on the matching `rsp_valid` bit.
- Back-pressure: requester 1 issues SUB lhs=10 rhs=3, holds `rsp_ready[1]`=0 for 4 cycles while requester 0 stays valid → `rsp_res`=7 stable, `req_ready`=0 throughout; after `rsp_ready[1]`=1 requester 0 is granted that same cycle.
- Simultaneous drain and issue: owner drains result of SLL lhs=1 rhs=4 (16) in the cycle requester 0 issues XOR lhs=0xFF rhs=0x0F → `rsp_full` stays 1, next `rsp_res`=0xF0, owner 0.
- Reset mid-operation: assert `reset_n`=0 while `rsp_full`=1 and owner stalled → `rsp_valid`=0 immediately (asynchronous), `rr_ptr`=0; after release requester 0 wins a two-way contention.
- Idle drive: no `req_valid` → `alu_lhs`=`alu_rhs`=0, command value 0, all `req_ready`=0 only when the slot is full; otherwise `req_ready`=0 because no bits are valid.
